vu_meter_bar: RTL
=================

Name: vu_meter_bar

Overview:
- Parametrised audio level meter that drives an LED bar graph from a stream of PCM samples.
- Sits after the I2S receiver: takes sample words with a valid strobe and tracks the peak magnitude over a programmable display window.
- Outputs a decaying bar, a peak-hold dot and a clip flag.
- Generalises the fixed 16-bit/8-LED meter with signed input, segment count, decay, peak hold and output polarity as parameters.

Parameters:
- DATA_WIDTH, 16, sample width in bits; must be an integer multiple of NUM_LEDS.
- NUM_LEDS, 8, number of bar segments; GROUP = DATA_WIDTH/NUM_LEDS bits per segment.
- UPDATE_DIV, 3000000, clk cycles per display update (tick period); must be ≥ 2.
- PEAK_HOLD_TICKS, 4, number of ticks the peak dot holds before falling.
- SIGNED_IN, 1, 1 = data_in is two's complement, 0 = unsigned magnitude.
- ACTIVE_LOW, 1, 1 = led outputs are inverted (0 = lit).
- LW = $clog2(NUM_LEDS+1); derived, not overridable.

Ports:
- clk  input  1  board clock (25 MHz).
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe; data_in is valid this cycle.
- data_in  input  DATA_WIDTH  audio sample.
- led  output  NUM_LEDS  bar graph; bit 0 is the lowest segment.
- bar_level  output  LW  current bar height, 0..NUM_LEDS.
- peak_level  output  LW  current peak-dot position, 0..NUM_LEDS (0 = no dot).
- clip  output  1  a full-scale sample occurred in the last completed window.

Behaviour:
- All state is updated on posedge clk; rst is synchronous and active-high.
- Reset values:
  - tick counter = 0, win_max = 0, win_clip = 0.
  - bar_level = 0, peak_level = 0, hold counter = 0, clip = 0.
  - led = all-off: all ones if ACTIVE_LOW, otherwise all zeros.
  - Reset asserted mid-window discards the window.
- Magnitude:
  - SIGNED_IN=1: mag = |data_in|. The most-negative code saturates to 2^(DATA_WIDTH-1)-1 and counts as full scale.
  - SIGNED_IN=0: mag = data_in. Full scale is all ones.
- Window:
  - On sample_valid, win_max <= max(win_max, mag).
  - win_clip is set if mag equals full scale.
- Tick:
  - The counter runs 0..UPDATE_DIV-1 and wraps. tick = (counter == UPDATE_DIV-1).
  - On tick the window closes.
  - A sample_valid on the tick cycle belongs to the closing window.
  - win_max and win_clip clear to 0 on the next cycle, except that the tick-cycle sample is included in the closing window.
- Quantisation of a closed window:
  - new_level = 0 if win_max == 0.
  - Otherwise new_level = floor(msb_index(win_max)/GROUP) + 1.
  - Example, 16/8: msb 0..1 → 1, msb 14..15 → 8.
- Bar update (one cycle after tick):
  - If new_level ≥ bar_level: bar_level <= new_level (instant attack).
  - Otherwise bar_level <= bar_level - 1 (one segment per tick decay).
- Peak update (same cycle as the bar update):
  - If new_level ≥ peak_level: peak_level <= new_level and hold <= PEAK_HOLD_TICKS.
  - Else if hold > 0: hold <= hold - 1.
  - Else peak_level <= max(peak_level - 1, next bar_level).
- Clip: clip <= win_clip on the bar update cycle and holds until the next update.
- led output:
  - Registered, updated the same cycle as bar_level and peak_level.
  - raw[i] = (i < bar_level) OR (peak_level != 0 AND i == peak_level-1).
  - led = ACTIVE_LOW ? ~raw : raw.
- Latency: a sample on the tick cycle appears on led, bar_level and clip exactly 1 clk later. Otherwise the latency is up to one window.
- No arithmetic overflow: levels are bounded by NUM_LEDS, and decrement stops at 0.

Test Plan:
- Reset, defaults with UPDATE_DIV=10, no samples for 3 ticks → bar_level=0, peak_level=0, led=8'hFF, clip=0.
- Single sample 16'sh0100 (msb 8) then silence → bar_level=5 and led=8'b1110_0000 after the first tick. The bar falls 4,3,2,1,0 on successive ticks. The peak stays at 5 for 4 ticks, then falls but never below the bar.
- Samples 16'sh0010 and 16'sh4000 in the same window → new_level=8, led=8'h00, peak_level=8, clip=0.
- Sample 16'sh8000 (most negative) → mag=16'h7FFF, clip=1 for exactly one update period, bar_level=8.
- Sample_valid with 16'sh0003 on the tick cycle → counted in the closing window: bar_level=1 one cycle later, and the next window's win_max starts at 0.
- rst asserted mid-window with bar_level=6 → all outputs return to reset values the next cycle, and a pending window maximum is not displayed.
- Parameter variant NUM_LEDS=4, SIGNED_IN=0, ACTIVE_LOW=0: sample 16'h00F0 → level 2 (msb 7 / 4 + 1), led=4'b0011.

Source files
------------

// File: rtl/vu_meter_bar.sv
// vu_meter_bar: LED bar-graph level meter fed by a PCM sample stream.
// Tracks per-window peak magnitude, shows a decaying bar, a peak-hold dot and a clip flag.
`default_nettype none

module vu_meter_bar #(
    parameter int DATA_WIDTH      = 16,
    parameter int NUM_LEDS        = 8,
    parameter int UPDATE_DIV      = 3000000,
    parameter int PEAK_HOLD_TICKS = 4,
    parameter int SIGNED_IN       = 1,
    parameter int ACTIVE_LOW      = 1,
    localparam int LW             = $clog2(NUM_LEDS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [NUM_LEDS-1:0]   led,
    output logic [LW-1:0]         bar_level,
    output logic [LW-1:0]         peak_level,
    output logic                  clip
);

    localparam int GROUP = DATA_WIDTH / NUM_LEDS;
    localparam int CW    = $clog2(UPDATE_DIV);
    localparam int HW    = (PEAK_HOLD_TICKS > 0) ? $clog2(PEAK_HOLD_TICKS + 1) : 1;

    localparam logic [DATA_WIDTH-1:0] MOST_NEG   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] POS_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] FULL_SCALE = (SIGNED_IN != 0) ? POS_MAX : {DATA_WIDTH{1'b1}};
    localparam logic [NUM_LEDS-1:0]   LED_INVERT = {NUM_LEDS{ACTIVE_LOW != 0}};

    logic [CW-1:0]         tick_cnt;
    logic                  tick;
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] win_max;
    logic [DATA_WIDTH-1:0] win_max_nxt;
    logic                  win_clip;
    logic                  win_clip_nxt;
    logic [LW-1:0]         new_level;
    logic [LW-1:0]         bar_nxt;
    logic [LW-1:0]         peak_nxt;
    logic [HW-1:0]         hold;
    logic [HW-1:0]         hold_nxt;
    logic [NUM_LEDS-1:0]   raw;

    // Segment index of the highest set bit, plus one; zero magnitude gives level 0.
    function automatic logic [LW-1:0] quantize(input logic [DATA_WIDTH-1:0] m);
        logic [LW-1:0] lvl;
        lvl = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (m[i]) lvl = LW'(i / GROUP + 1);
        end
        return lvl;
    endfunction

    assign tick = (tick_cnt == CW'(UPDATE_DIV - 1));

    always_comb begin
        mag = data_in;
        if (SIGNED_IN != 0 && data_in[DATA_WIDTH-1]) begin
            mag = (data_in == MOST_NEG) ? POS_MAX : (~data_in + DATA_WIDTH'(1));
        end
    end

    // The tick-cycle sample is folded in here so it lands in the closing window.
    always_comb begin
        win_max_nxt  = win_max;
        win_clip_nxt = win_clip;
        if (sample_valid) begin
            if (mag > win_max) win_max_nxt = mag;
            if (mag == FULL_SCALE) win_clip_nxt = 1'b1;
        end
    end

    assign new_level = quantize(win_max_nxt);
    assign bar_nxt   = (new_level >= bar_level) ? new_level : (bar_level - LW'(1));

    always_comb begin
        peak_nxt = peak_level;
        hold_nxt = hold;
        if (new_level >= peak_level) begin
            peak_nxt = new_level;
            hold_nxt = HW'(PEAK_HOLD_TICKS);
        end else if (hold != '0) begin
            hold_nxt = hold - HW'(1);
        end else begin
            peak_nxt = ((peak_level - LW'(1)) > bar_nxt) ? (peak_level - LW'(1)) : bar_nxt;
        end
    end

    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            raw[i] = (LW'(i) < bar_nxt) || (LW'(i + 1) == peak_nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt   <= '0;
            win_max    <= '0;
            win_clip   <= 1'b0;
            bar_level  <= '0;
            peak_level <= '0;
            hold       <= '0;
            clip       <= 1'b0;
            led        <= LED_INVERT;
        end else begin
            tick_cnt <= tick ? '0 : (tick_cnt + CW'(1));
            if (tick) begin
                win_max    <= '0;
                win_clip   <= 1'b0;
                bar_level  <= bar_nxt;
                peak_level <= peak_nxt;
                hold       <= hold_nxt;
                clip       <= win_clip_nxt;
                led        <= raw ^ LED_INVERT;
            end else begin
                win_max  <= win_max_nxt;
                win_clip <= win_clip_nxt;
            end
        end
    end

endmodule

`default_nettype wire
